// File: rtl/food_placer_if.sv
// Handshake/bus bundle between the food placer, the random box generator,
// the snake body RAM and the renderer/collision logic.
interface food_placer_if #(
  parameter int LEN_W = 6
) ();
  logic             start;
  logic             eaten;
  logic [9:0]       cand_x;
  logic [9:0]       cand_y;
  logic             regen;
  logic [LEN_W:0]   snake_len;
  logic [LEN_W-1:0] body_addr;
  logic [9:0]       body_x;
  logic [9:0]       body_y;
  logic [9:0]       food_x;
  logic [9:0]       food_y;
  logic             food_valid;
  logic             busy;
  logic             place_fail;

  // environment side: game control, generator, body RAM
  modport master (
    output start, eaten, cand_x, cand_y, snake_len, body_x, body_y,
    input  regen, body_addr, food_x, food_y, food_valid, busy, place_fail
  );

  // placer side
  modport slave (
    input  start, eaten, cand_x, cand_y, snake_len, body_x, body_y,
    output regen, body_addr, food_x, food_y, food_valid, busy, place_fail
  );
endinterface

// File: rtl/food_placer.sv
// Food placer: requests candidates from the random box generator, rejects
// ones outside the field or on top of a snake segment (serial body RAM scan),
// and commits the first legal one as the new food position.
module food_placer #(
  parameter logic [9:0] X_MAX     = 10'd620,
  parameter logic [9:0] Y_MAX     = 10'd460,
  parameter int         MAX_LEN   = 64,
  parameter int         LEN_W     = 6,
  parameter int         CAND_WAIT = 2,
  parameter logic [7:0] MAX_TRIES = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  food_placer_if.slave bus
);

  localparam logic [LEN_W:0] LEN_CAP  = (LEN_W+1)'(MAX_LEN);
  localparam logic [3:0]     WAIT_END = 4'(CAND_WAIT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RANGE, SCAN, COMMIT} state_t;

  state_t         state;
  logic [3:0]     wait_cnt;
  logic [7:0]     tries;
  logic [9:0]     hold_x, hold_y;
  logic [LEN_W:0] scan_len, scan_idx;

  logic [LEN_W:0] len_clamped;
  logic [7:0]     tries_nxt;
  logic           give_up;
  logic           out_of_range;
  logic           body_hit;

  // Derived decisions: clamped length, saturating retry count, reject causes.
  // scan_idx==0 means no read data has come back yet, so no compare.
  always_comb begin
    len_clamped  = (bus.snake_len > LEN_CAP) ? LEN_CAP : bus.snake_len;
    tries_nxt    = (tries == 8'hFF) ? tries : tries + 8'd1;
    give_up      = (tries_nxt >= MAX_TRIES);
    out_of_range = (hold_x > X_MAX) || (hold_y > Y_MAX);
    body_hit     = (scan_idx != '0) && (bus.body_x == hold_x) && (bus.body_y == hold_y);
  end

  // Placement FSM; every output is a register. start wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      tries          <= '0;
      hold_x         <= '0;
      hold_y         <= '0;
      scan_len       <= '0;
      scan_idx       <= '0;
      bus.regen      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.body_addr  <= '0;
      bus.food_x     <= '0;
      bus.food_y     <= '0;
      bus.food_valid <= 1'b0;
      bus.place_fail <= 1'b0;
    end else begin
      bus.regen <= 1'b0;
      if (bus.start) begin
        state          <= REQ;
        bus.regen      <= 1'b1;
        bus.busy       <= 1'b1;
        bus.food_valid <= 1'b0;
        bus.place_fail <= 1'b0;
        tries          <= '0;
      end else begin
        case (state)
          IDLE: if (bus.eaten) begin
            state          <= REQ;
            bus.regen      <= 1'b1;
            bus.busy       <= 1'b1;
            bus.food_valid <= 1'b0;
            tries          <= '0;
          end
          REQ: begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
          WAIT: if (wait_cnt == WAIT_END) begin
            hold_x <= bus.cand_x;
            hold_y <= bus.cand_y;
            state  <= RANGE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
          RANGE: if (out_of_range) begin
            tries <= tries_nxt;
            if (give_up) begin
              state          <= IDLE;
              bus.busy       <= 1'b0;
              bus.place_fail <= 1'b1;
            end else begin
              state     <= REQ;
              bus.regen <= 1'b1;
            end
          end else begin
            state         <= SCAN;
            scan_len      <= len_clamped;
            scan_idx      <= '0;
            bus.body_addr <= '0;
          end
          SCAN: if (body_hit) begin
            tries <= tries_nxt;
            if (give_up) begin
              state          <= IDLE;
              bus.busy       <= 1'b0;
              bus.place_fail <= 1'b1;
            end else begin
              state     <= REQ;
              bus.regen <= 1'b1;
            end
          end else if (scan_idx == scan_len) begin
            state <= COMMIT;
          end else begin
            if (scan_idx + 1'b1 < scan_len)
              bus.body_addr <= scan_idx[LEN_W-1:0] + 1'b1;
            scan_idx <= scan_idx + 1'b1;
          end
          COMMIT: begin
            state          <= IDLE;
            bus.food_x     <= hold_x;
            bus.food_y     <= hold_y;
            bus.food_valid <= 1'b1;
            bus.busy       <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: directed scenarios plus randomized placements, all
// checked every cycle against a per-cycle output schedule derived from the
// placement rules, with a few hand-computed literal expectations on top.
module tb_food_placer;

  localparam int MT   = 3;    // MAX_TRIES used for the DUT instance
  localparam int CW   = 2;    // CAND_WAIT
  localparam int XMAX = 620;
  localparam int YMAX = 460;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  food_placer_if #(.LEN_W(6)) bus ();

  food_placer #(.MAX_TRIES(8'(MT))) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  // body RAM and candidate stream
  logic [9:0] bx [64];
  logic [9:0] by [64];
  logic [9:0] cxs [4096];
  logic [9:0] cys [4096];
  int gi = 0;
  int regen_cnt = 0;

  always @(posedge clk) begin
    bus.body_x <= bx[bus.body_addr];
    bus.body_y <= by[bus.body_addr];
  end

  // generator: each regen pulse presents the next candidate from the stream
  initial forever begin
    @(negedge clk);
    if (bus.regen) begin
      bus.cand_x = cxs[gi % 4096];
      bus.cand_y = cys[gi % 4096];
      gi++;
      regen_cnt++;
    end
  end

  // ---------------- reference model: expected outputs per cycle ----------------
  typedef struct packed {
    logic       regen, busy, fv, fail;
    logic [9:0] fx, fy;
    logic       chk;
    logic [5:0] addr;
  } frame_t;

  frame_t e;
  frame_t q[$];
  int mi = 0;

  // Build the whole schedule for one placement from the candidates it will get.
  function automatic void plan(input bit clr_fail);
    int L;
    int m;
    int s;
    bit ok;
    logic [9:0] cx, cy;
    frame_t f;
    L = (int'(bus.snake_len) > 64) ? 64 : int'(bus.snake_len);
    q.delete();
    f = e;
    f.fail = clr_fail ? 1'b0 : e.fail;
    f.fv = 1'b0; f.busy = 1'b1; f.chk = 1'b0; f.regen = 1'b0;
    for (int a = 0; a < MT; a++) begin
      cx = cxs[(mi + a) % 4096];
      cy = cys[(mi + a) % 4096];
      f.regen = 1'b1; q.push_back(f); f.regen = 1'b0;
      for (int w = 0; w < CW + 1; w++) q.push_back(f);   // wait cycles + range check
      ok = (int'(cx) <= XMAX) && (int'(cy) <= YMAX);
      if (ok) begin
        m = -1;
        for (int i = 0; i < L; i++)
          if (m < 0 && bx[i] == cx && by[i] == cy) m = i;
        s = (m < 0) ? L + 1 : m + 2;
        for (int j = 0; j < s; j++) begin
          f.chk = 1'b1;
          f.addr = (L == 0) ? 6'd0 : 6'((j < L) ? j : L - 1);
          q.push_back(f);
        end
        f.chk = 1'b0;
        ok = (m < 0);
      end
      if (ok) begin
        q.push_back(f);                                    // commit cycle
        f.busy = 1'b0; f.fv = 1'b1; f.fx = cx; f.fy = cy;
        q.push_back(f);
        return;
      end
    end
    f.busy = 1'b0; f.fail = 1'b1;
    q.push_back(f);
  endfunction

  initial begin
    e = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        e = '0;
        q.delete();
      end else begin
        if (e.regen) mi++;
        if (bus.start) plan(1'b1);
        else if (bus.eaten && !e.busy) plan(1'b0);
        if (q.size() != 0) e = q.pop_front();
        else begin e.regen = 1'b0; e.chk = 1'b0; end
      end
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      total++;
      if ({bus.regen, bus.busy, bus.food_valid, bus.place_fail, bus.food_x, bus.food_y} !==
          {e.regen, e.busy, e.fv, e.fail, e.fx, e.fy}) begin
        bad++;
        $display("FAIL cycle t=%0t got regen=%b busy=%b fv=%b fail=%b food=(%0d,%0d) want regen=%b busy=%b fv=%b fail=%b food=(%0d,%0d)",
                 $time, bus.regen, bus.busy, bus.food_valid, bus.place_fail, bus.food_x, bus.food_y,
                 e.regen, e.busy, e.fv, e.fail, e.fx, e.fy);
      end
      if (e.chk) begin
        total++;
        if (bus.body_addr !== e.addr) begin
          bad++;
          $display("FAIL body_addr t=%0t got=%0d want=%0d", $time, bus.body_addr, e.addr);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input bit s, input bit ev);
    bus.start = s; bus.eaten = ev;
    @(negedge clk);
    bus.start = 1'b0; bus.eaten = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((bus.busy || q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL timeout busy=%b pending=%0d", bus.busy, q.size());
    end
  endtask

  task automatic set_cand(input int k, input int x, input int y);
    cxs[(gi + k) % 4096] = 10'(x);
    cys[(gi + k) % 4096] = 10'(y);
  endtask

  int r0;
  int lat;

  initial begin
    bus.start = 0; bus.eaten = 0; bus.cand_x = 0; bus.cand_y = 0; bus.snake_len = 0;
    for (int i = 0; i < 64; i++) begin bx[i] = 10'd1000; by[i] = 10'd1000; end
    for (int i = 0; i < 4096; i++) begin cxs[i] = 0; cys[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_regen", bus.regen, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fv", bus.food_valid, 0);
    chk("rst_fail", bus.place_fail, 0);
    chk("rst_food", {bus.food_x, bus.food_y}, 0);
    chk("rst_addr", bus.body_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: empty snake, best-case latency
    bus.snake_len = 0;
    set_cand(0, 100, 200);
    r0 = regen_cnt;
    pulse(1, 0);
    lat = 0;
    while (!bus.food_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("t1_latency", lat, 6);
    chk("t1_food_x", bus.food_x, 100);
    chk("t1_food_y", bus.food_y, 200);
    wait_done(100);
    chk("t1_regens", regen_cnt - r0, 1);

    // 2: candidate on the last body segment, then a clear one
    bx[0] = 40; by[0] = 40; bx[1] = 60; by[1] = 40; bx[2] = 100; by[2] = 200;
    bus.snake_len = 3;
    set_cand(0, 100, 200); set_cand(1, 300, 300);
    r0 = regen_cnt;
    pulse(1, 0);
    wait_done(200);
    chk("t2_regens", regen_cnt - r0, 2);
    chk("t2_food", {bus.food_x, bus.food_y}, {10'd300, 10'd300});
    chk("t2_fv", bus.food_valid, 1);

    // 3: two out-of-range, then the inclusive corner
    bus.snake_len = 0;
    set_cand(0, 640, 0); set_cand(1, 0, 480); set_cand(2, 620, 460);
    r0 = regen_cnt;
    pulse(0, 1);
    wait_done(200);
    chk("t3_regens", regen_cnt - r0, 3);
    chk("t3_food", {bus.food_x, bus.food_y}, {10'd620, 10'd460});

    // 4: everything out of range -> give up after MAX_TRIES
    set_cand(0, 700, 0); set_cand(1, 0, 900); set_cand(2, 1023, 1023);
    r0 = regen_cnt;
    pulse(0, 1);
    wait_done(200);
    chk("t4_regens", regen_cnt - r0, 3);
    chk("t4_fail", bus.place_fail, 1);
    chk("t4_fv", bus.food_valid, 0);
    chk("t4_busy", bus.busy, 0);
    set_cand(0, 5, 5);
    pulse(1, 0);
    chk("t4_fail_cleared", bus.place_fail, 0);
    wait_done(200);

    // 5: eaten during scan ignored; start during scan restarts with fresh try count
    for (int i = 0; i < 10; i++) begin bx[i] = 10'(i * 10); by[i] = 10'd500; end
    bus.snake_len = 10;
    set_cand(0, 900, 0); set_cand(1, 7, 7); set_cand(2, 901, 0); set_cand(3, 902, 0);
    set_cand(4, 8, 8);
    r0 = regen_cnt;
    pulse(1, 0);
    for (int k = 0; k < 14; k++) begin
      bus.eaten = (k == 10);
      bus.start = (k == 13);
      @(negedge clk);
    end
    bus.start = 0; bus.eaten = 0;
    wait_done(300);
    chk("t5_regens", regen_cnt - r0, 5);
    chk("t5_food", {bus.food_x, bus.food_y}, {10'd8, 10'd8});
    chk("t5_fail", bus.place_fail, 0);

    // 6: async reset in the middle of the candidate wait
    set_cand(0, 1, 1);
    pulse(1, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_regen", bus.regen, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_fv", bus.food_valid, 0);
    chk("t6_fail", bus.place_fail, 0);
    chk("t6_food", {bus.food_x, bus.food_y}, 0);
    chk("t6_addr", bus.body_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // randomized placements
    for (int it = 0; it < 150; it++) begin
      bus.snake_len = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(65, 127))
                                                  : 7'($urandom_range(0, 64));
      for (int i = 0; i < 64; i++) begin
        bx[i] = 10'($urandom_range(0, 15) * 41);
        by[i] = 10'($urandom_range(0, 15) * 30);
      end
      for (int k = 0; k < 16; k++) begin
        int sel;
        int idx;
        sel = $urandom_range(0, 9);
        idx = $urandom_range(0, 63);
        if (sel < 3) begin
          if ($urandom_range(0, 1) == 1) set_cand(k, $urandom_range(621, 1023), $urandom_range(0, 1023));
          else set_cand(k, $urandom_range(0, 620), $urandom_range(461, 1023));
        end else if (sel < 7) set_cand(k, int'(bx[idx]), int'(by[idx]));
        else set_cand(k, $urandom_range(0, 620), $urandom_range(0, 460));
      end
      case ($urandom_range(0, 3))
        0, 3: pulse(1, 0);
        1:    pulse(0, 1);
        default: pulse(1, 1);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        if ($urandom_range(0, 1) == 1) pulse(1, 0); else pulse(0, 1);
      end
      wait_done(3000);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
